nios2_ocimem_arbiter: RTL and testbench

- Sequences and arbitrates the single-port OCI debug RAM between two requesters.
- Requester 1: JTAG debug host, via the sysclk-domain take_action_ocimem_a/b and take_no_action_ocimem_a strobes plus jdo from the debug slave wrapper.
- Requester 2: the CPU's debug-memory Avalon-MM slave port.
- Returns JTAG read data on MonDReg.

---
 rtl/nios2_ocimem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ocimem_arbiter.sv
// OCI debug RAM sequencer: arbitrates the single-port RAM between JTAG debug commands and the CPU slave port.
// Optional feature macro OCIMEM_WRITE_PROTECT_EN: CPU writes without avs_debugaccess are acknowledged but dropped.
module nios2_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_READ = 2'd2, ST_RWAIT = 2'd3} state_t;
  typedef enum logic [1:0] {J_LOAD = 2'd0, J_LOAD_RD = 2'd1, J_RD_NEXT = 2'd2, J_WR = 2'd3} jcmd_t;

  state_t            state_r;
  jcmd_t             jcmd_r;
  jcmd_t             new_cmd_s;
  logic              new_valid_s;
  logic              accept_s;
  logic              incoming_ram_s;
  logic              jtag_ram_s;
  logic              cpu_req_s;
  logic              cpu_wr_en_s;
  logic              unused_s;
  logic              jpend_r;
  logic              jbusy_r;
  logic              overrun_r;
  logic              last_cpu_r;
  logic              owner_jtag_r;
  logic              wait_r;
  logic              ram_wren_r;
  logic [ADDR_W-1:0] jaddr_r;
  logic [ADDR_W-1:0] jaddr_in_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [31:0]       jdata_r;
  logic [31:0]       ram_wdata_r;
  logic [31:0]       mon_r;
  logic [31:0]       rdata_r;
  logic [3:0]        ram_byteen_r;
  logic [1:0]        cnt_r;

`ifdef OCIMEM_WRITE_PROTECT_EN
  assign cpu_wr_en_s = avs_debugaccess;
  assign unused_s    = ^{jdo[37:36], jdo[2:0]};
`else
  assign cpu_wr_en_s = 1'b1;
  assign unused_s    = ^{jdo[37:36], jdo[2:0], avs_debugaccess};
`endif

  // Decode the JTAG strobes into one command; the write strobe has priority.
  always_comb begin
    new_valid_s = 1'b0;
    new_cmd_s   = J_LOAD;
    if (take_action_ocimem_b) begin
      new_valid_s = 1'b1;
      new_cmd_s   = J_WR;
    end else if (take_action_ocimem_a) begin
      new_valid_s = 1'b1;
      new_cmd_s   = jdo[35] ? J_LOAD_RD : J_LOAD;
    end else if (take_no_action_ocimem_a) begin
      new_valid_s = 1'b1;
      new_cmd_s   = J_RD_NEXT;
    end else begin
      new_valid_s = 1'b0;
      new_cmd_s   = J_LOAD;
    end
  end

  // An incoming RAM-bound strobe counts as a contender so a same-cycle tie is arbitrated fairly.
  assign accept_s       = new_valid_s & ~jbusy_r;
  assign incoming_ram_s = accept_s & (new_cmd_s != J_LOAD);
  assign jtag_ram_s     = jpend_r & (jcmd_r != J_LOAD);
  assign cpu_req_s      = (avs_read | avs_write) & wait_r;

  // Arbitration FSM, JTAG command latch and all registered RAM/bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      jcmd_r       <= J_LOAD;
      jpend_r      <= 1'b0;
      jbusy_r      <= 1'b0;
      last_cpu_r   <= 1'b1;
      owner_jtag_r <= 1'b0;
      wait_r       <= 1'b1;
      ram_wren_r   <= 1'b0;
      jaddr_r      <= '0;
      jaddr_in_r   <= '0;
      ram_addr_r   <= '0;
      jdata_r      <= 32'h0;
      ram_wdata_r  <= 32'h0;
      mon_r        <= 32'h0;
      rdata_r      <= 32'h0;
      ram_byteen_r <= 4'h0;
      cnt_r        <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wait_r     <= 1'b1;
          ram_wren_r <= 1'b0;
          if (jpend_r && (jcmd_r == J_LOAD)) begin
            jaddr_r <= jaddr_in_r;
            jpend_r <= 1'b0;
            jbusy_r <= 1'b0;
          end
          if ((jtag_ram_s || incoming_ram_s) && (!cpu_req_s || last_cpu_r)) begin
            // JTAG wins; if its strobe is only now arriving, hold here one cycle for the latch.
            if (jtag_ram_s) begin
              owner_jtag_r <= 1'b1;
              last_cpu_r   <= 1'b0;
              jpend_r      <= 1'b0;
              case (jcmd_r)
                J_WR: begin
                  ram_addr_r   <= jaddr_r;
                  ram_wdata_r  <= jdata_r;
                  ram_byteen_r <= 4'hF;
                  ram_wren_r   <= 1'b1;
                  state_r      <= ST_WRITE;
                end
                J_LOAD_RD: begin
                  jaddr_r    <= jaddr_in_r;
                  ram_addr_r <= jaddr_in_r;
                  state_r    <= ST_READ;
                end
                default: begin
                  ram_addr_r <= jaddr_r;
                  state_r    <= ST_READ;
                end
              endcase
            end
          end else if (cpu_req_s) begin
            owner_jtag_r <= 1'b0;
            last_cpu_r   <= 1'b1;
            ram_addr_r   <= avs_address;
            if (avs_write) begin
              ram_wdata_r  <= avs_writedata;
              ram_byteen_r <= avs_byteenable;
              ram_wren_r   <= cpu_wr_en_s;
              wait_r       <= 1'b0;
              state_r      <= ST_WRITE;
            end else begin
              state_r <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          ram_wren_r <= 1'b0;
          wait_r     <= 1'b1;
          state_r    <= ST_IDLE;
          if (owner_jtag_r) begin
            jaddr_r <= jaddr_r + ADDR_W'(1);
            jbusy_r <= 1'b0;
          end
        end
        ST_READ: begin
          cnt_r   <= 2'(RD_LAT - 1);
          state_r <= ST_RWAIT;
        end
        ST_RWAIT: begin
          if (cnt_r == 2'd0) begin
            state_r <= ST_IDLE;
            if (owner_jtag_r) begin
              mon_r   <= ram_rdata;
              jaddr_r <= jaddr_r + ADDR_W'(1);
              jbusy_r <= 1'b0;
            end else begin
              rdata_r <= ram_rdata;
              wait_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          ram_wren_r <= 1'b0;
          wait_r     <= 1'b1;
        end
      endcase
      if (accept_s) begin
        jpend_r    <= 1'b1;
        jbusy_r    <= 1'b1;
        jcmd_r     <= new_cmd_s;
        jaddr_in_r <= jdo[ADDR_W+16:17];
        jdata_r    <= jdo[34:3];
      end
    end
  end

  // Sticky overrun flag: a strobe landed while a JTAG command was still outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_r <= 1'b0;
    end else if (new_valid_s && jbusy_r) begin
      overrun_r <= 1'b1;
    end
  end

  assign avs_readdata    = rdata_r;
  assign avs_waitrequest = wait_r;
  assign ram_addr        = ram_addr_r;
  assign ram_wren        = ram_wren_r;
  assign ram_byteen      = ram_byteen_r;
  assign ram_wdata       = ram_wdata_r;
  assign MonDReg         = mon_r;
  assign jtag_busy       = jbusy_r;
  assign jtag_overrun    = overrun_r;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Scoreboard bench for nios2_ocimem_arbiter: directed JTAG/CPU traffic, expectations queued at issue time.
// Completion cycles are counted from the clock edge that samples the strobe/request.
module tb_nios2_ocimem_arbiter;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [37:0] jdo = 38'd0;
  logic [7:0]  avs_address = 8'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [3:0]  avs_byteenable = 4'd0;
  logic        avs_debugaccess = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic [31:0] MonDReg;
  logic        jtag_busy;
  logic        jtag_overrun;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .jdo(jdo),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_debugaccess(avs_debugaccess), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
  );

  // Single-port RAM model with one cycle of read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit chk; logic [31:0] data; int due; } exp_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  exp_t cpu_q[$];
  exp_t jtag_q[$];
  wr_t  w_q[$];
  exp_t ce, je;
  wr_t  we;
  int   checks = 0;
  int   failures = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT completes a CPU access, a RAM write or a JTAG command.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!avs_waitrequest) begin
        if (cpu_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL cpu_unexpected: waitrequest low at cycle %0d with nothing outstanding", cyc);
        end else begin
          ce = cpu_q.pop_front();
          check("cpu_done_cycle", 32'(cyc), 32'(ce.due));
          if (ce.chk) check("cpu_readdata", avs_readdata, ce.data);
        end
      end
      if (ram_wren) begin
        if (w_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ram_unexpected_write: addr %h data %h expected no write", ram_addr, ram_wdata);
        end else begin
          we = w_q.pop_front();
          check("ram_addr", {24'd0, ram_addr}, {24'd0, we.addr});
          check("ram_wdata", ram_wdata, we.data);
          check("ram_byteen", {28'd0, ram_byteen}, {28'd0, we.be});
        end
      end
      if (prev_busy && !jtag_busy) begin
        if (jtag_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL jtag_unexpected: busy fell at cycle %0d with nothing outstanding", cyc);
        end else begin
          je = jtag_q.pop_front();
          check("jtag_done_cycle", 32'(cyc), 32'(je.due));
          if (je.chk) check("MonDReg", MonDReg, je.data);
        end
      end
    end
    prev_busy <= jtag_busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 LOAD, 1 LOAD with read, 2 read-next, 3 write
  task automatic jtag_pulse(input int kind, input logic [7:0] a, input logic [31:0] wd);
    jdo = 38'd0;
    case (kind)
      0: begin jdo[24:17] = a; take_action_ocimem_a = 1'b1; end
      1: begin jdo[24:17] = a; jdo[35] = 1'b1; take_action_ocimem_a = 1'b1; end
      2: take_no_action_ocimem_a = 1'b1;
      default: begin jdo[34:3] = wd; take_action_ocimem_b = 1'b1; end
    endcase
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic jtag_cmd(input int kind, input logic [7:0] a, input logic [31:0] wd,
                          input bit chk, input logic [31:0] expv, input int due_off);
    exp_t en;
    en.chk = chk; en.data = expv; en.due = cyc + 1 + due_off;
    jtag_q.push_back(en);
    jtag_pulse(kind, a, wd);
    check("jtag_busy_rise", {31'd0, jtag_busy}, 32'd1);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.addr = a; w.data = d; w.be = be;
    w_q.push_back(w);
  endtask

  task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        input bit dbg, input logic [31:0] expv, input int due_off);
    exp_t en;
    bit done;
    en.chk = ~wr; en.data = expv; en.due = cyc + 1 + due_off;
    cpu_q.push_back(en);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_debugaccess = dbg;
    avs_write = wr; avs_read = ~wr;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL cpu_timeout: waitrequest still 1 after 40 cycles, expected completion");
    end
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i), 8'h5A, ~8'(i)};
    mem[16] = 32'hDEADBEEF;
    tick(3);
    reset_n = 1'b1;
    check("rst_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
    check("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_MonDReg", MonDReg, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_busy", {31'd0, jtag_busy}, 32'd0);
    check("rst_overrun", {31'd0, jtag_overrun}, 32'd0);
    tick(2);

    // LOAD with read at 0x10, then read-next proves jaddr advanced to 0x11
    jtag_cmd(1, 8'h10, 32'd0, 1'b1, 32'hDEADBEEF, 3); tick(6);
    jtag_cmd(2, 8'h00, 32'd0, 1'b1, 32'hC0115AEE, 3); tick(6);

    // LOAD 0xFF, write, read-next wraps to 0x00, read back 0xFF
    jtag_cmd(0, 8'hFF, 32'd0, 1'b0, 32'd0, 1); tick(3);
    push_wr(8'hFF, 32'h12345678, 4'hF);
    jtag_cmd(3, 8'h00, 32'h12345678, 1'b0, 32'd0, 2); tick(4);
    jtag_cmd(2, 8'h00, 32'd0, 1'b1, 32'hC0005AFF, 3); tick(6);
    jtag_cmd(1, 8'hFF, 32'd0, 1'b1, 32'h12345678, 3); tick(6);

    // CPU partial write then read back
    push_wr(8'h05, 32'hA5A5A5A5, 4'b0011);
    cpu_op(1'b1, 8'h05, 32'hA5A5A5A5, 4'b0011, 1'b1, 32'd0, 0); tick(3);
    cpu_op(1'b0, 8'h05, 32'd0, 4'hF, 1'b1, 32'hC005A5A5, 1 + RD_LAT); tick(3);

    // Tie with last grant = CPU: JTAG first, CPU after
    fork
      cpu_op(1'b0, 8'h20, 32'd0, 4'hF, 1'b1, 32'hC0205ADF, 6);
      jtag_cmd(2, 8'h00, 32'd0, 1'b1, 32'hC0005AFF, 3);
    join
    tick(3);
    jtag_cmd(2, 8'h00, 32'd0, 1'b1, 32'hC0015AFE, 3); tick(6);
    // Tie with last grant = JTAG: CPU first
    fork
      cpu_op(1'b0, 8'h21, 32'd0, 4'hF, 1'b1, 32'hC0215ADE, 2);
      jtag_cmd(2, 8'h00, 32'd0, 1'b1, 32'hC0025AFD, 5);
    join
    tick(6);

    // Overrun: second strobe one cycle after the first is dropped
    jtag_cmd(2, 8'h00, 32'd0, 1'b1, 32'hC0035AFC, 3);
    jtag_pulse(3, 8'h00, 32'h0BAD0BAD);
    check("overrun_set", {31'd0, jtag_overrun}, 32'd1);
    tick(6);
    check("overrun_sticky", {31'd0, jtag_overrun}, 32'd1);
    reset_n = 1'b0; tick(2); reset_n = 1'b1;
    check("overrun_cleared", {31'd0, jtag_overrun}, 32'd0);
    check("rst2_busy", {31'd0, jtag_busy}, 32'd0);
    check("rst2_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
    tick(2);
    jtag_cmd(2, 8'h00, 32'd0, 1'b1, 32'hC0005AFF, 3); tick(6);

`ifdef OCIMEM_WRITE_PROTECT_EN
    cpu_op(1'b1, 8'h06, 32'h11223344, 4'hF, 1'b0, 32'd0, 0); tick(3);
    cpu_op(1'b0, 8'h06, 32'd0, 4'hF, 1'b1, 32'hC0065AF9, 1 + RD_LAT); tick(3);
    push_wr(8'h06, 32'h11223344, 4'hF);
    cpu_op(1'b1, 8'h06, 32'h11223344, 4'hF, 1'b1, 32'd0, 0); tick(3);
`else
    push_wr(8'h06, 32'h11223344, 4'hF);
    cpu_op(1'b1, 8'h06, 32'h11223344, 4'hF, 1'b0, 32'd0, 0); tick(3);
`endif
    cpu_op(1'b0, 8'h06, 32'd0, 4'hF, 1'b0, 32'h11223344, 1 + RD_LAT); tick(4);

    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("jtag_q_drained", 32'(jtag_q.size()), 32'd0);
    check("wr_q_drained", 32'(w_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
